// File: rtl/data_sram_responder_pkg.sv
// Shared data_sram widths and the read-pipeline entry carried
// between the array and the response outputs.
package data_sram_responder_pkg;

   localparam int unsigned SRAM_DATA_W = 32;
   localparam int unsigned SRAM_STRB_W = 4;
   localparam int unsigned SRAM_ADDR_W = 32;

   typedef struct packed {
      logic                   valid;
      logic                   err;
      logic [SRAM_DATA_W-1:0] data;
   } sram_rd_entry_t;

endpackage

// File: rtl/data_sram_responder_sram_rd_delay_line.sv
// Fixed-latency register chain for read responses; data only moves
// with a valid entry so the tail holds the last returned word.
module sram_rd_delay_line
   import data_sram_responder_pkg::*;
#(
   parameter int unsigned LATENCY = 1
) (
   input  logic           clock,
   input  logic           reset,
   input  sram_rd_entry_t entry_i,
   output sram_rd_entry_t entry_o
);

   sram_rd_entry_t stage_q [LATENCY];
   sram_rd_entry_t stage_d [LATENCY];

   always_comb begin
      stage_d[0].valid = entry_i.valid;
      stage_d[0].err   = entry_i.err;
      stage_d[0].data  = entry_i.valid ? entry_i.data
                                       : stage_q[0].data;
      for (int i = 1; i < LATENCY; i++) begin
         stage_d[i].valid = stage_q[i-1].valid;
         stage_d[i].err   = stage_q[i-1].err;
         stage_d[i].data  = stage_q[i-1].valid ? stage_q[i-1].data
                                               : stage_q[i].data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
      end else begin
         for (int i = 0; i < LATENCY; i++) stage_q[i] <= stage_d[i];
      end
   end

   assign entry_o = stage_q[LATENCY-1];

endmodule

// File: rtl/data_sram_responder.sv
// Word-organised data memory behind the MEM-stage data_sram port:
// byte-strobed writes, fixed-latency reads, range-error sideband.
module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned RD_LATENCY  = 1,
   parameter logic [31:0] ERR_DATA    = 32'h0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   data_sram_en,
   input  logic                   data_sram_wr,
   input  logic [SRAM_ADDR_W-1:0] data_sram_addr,
   input  logic [SRAM_DATA_W-1:0] data_sram_wdata,
   input  logic [SRAM_STRB_W-1:0] data_sram_wstrb,
   output logic [SRAM_DATA_W-1:0] data_sram_rdata,
   output logic                   data_sram_rvalid,
   output logic                   data_sram_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

   logic [SRAM_DATA_W-1:0] mem_q [DEPTH_WORDS];

   logic [31:0]      offset;
   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic             wr_en;
   sram_rd_entry_t   entry_d;
   sram_rd_entry_t   tail;

   // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
   always_comb begin
      offset   = data_sram_addr - BASE_ADDR;
      in_range = {1'b0, offset} < SPAN;
      idx      = offset[IDX_W+1:2];
      wr_en    = data_sram_en & data_sram_wr & in_range;
      entry_d       = '0;
      entry_d.valid = data_sram_en & ~data_sram_wr;
      entry_d.err   = data_sram_en & ~in_range;
      entry_d.data  = in_range ? mem_q[idx] : ERR_DATA;
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int i = 0; i < SRAM_STRB_W; i++) begin
            if (data_sram_wstrb[i]) begin
               mem_q[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   sram_rd_delay_line #(
      .LATENCY (RD_LATENCY)
   ) u_rd_delay (
      .clock   (clock),
      .reset   (reset),
      .entry_i (entry_d),
      .entry_o (tail)
   );

   assign data_sram_rdata  = tail.data;
   assign data_sram_rvalid = tail.valid;
   assign data_sram_err    = tail.err;

endmodule

// File: tb/tb_data_sram_responder.sv
// Drives four responders (read latency 1..4) with shared stimulus and
// compares each against a scheduled-response memory model.
module tb_data_sram_responder;

   localparam int unsigned DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam logic [31:0] ERR   = 32'hDEAD_BEEF;
   localparam int          NL    = 4;

   typedef struct {
      bit          rst;
      bit          en;
      bit          wr;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } stim_t;

   typedef struct {
      int          due;
      bit          valid;
      bit          err;
      logic [31:0] data;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        en;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata_o  [NL];
   logic        rvalid_o [NL];
   logic        err_o    [NL];

   logic [31:0] mem_m [DEPTH];
   exp_t        expq  [NL][$];
   logic [31:0] last_m [NL];
   int          cyc     = 0;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < NL; g++) begin : g_dut
      data_sram_responder #(
         .DEPTH_WORDS (DEPTH),
         .BASE_ADDR   (BASE),
         .RD_LATENCY  (g + 1),
         .ERR_DATA    (ERR)
      ) u_dut (
         .clock            (clock),
         .reset            (reset),
         .data_sram_en     (en),
         .data_sram_wr     (wr),
         .data_sram_addr   (addr),
         .data_sram_wdata  (wdata),
         .data_sram_wstrb  (wstrb),
         .data_sram_rdata  (rdata_o[g]),
         .data_sram_rvalid (rvalid_o[g]),
         .data_sram_err    (err_o[g])
      );
   end

   // Apply one request, update the model, advance past the edge.
   task automatic drive(input stim_t st);
      logic [31:0] off;
      bit          inr;
      int          edge_n;
      exp_t        e;
      reset = st.rst;
      en    = st.en;
      wr    = st.wr;
      addr  = st.a;
      wdata = st.d;
      wstrb = st.s;
      off    = st.a - BASE;
      inr    = off < DEPTH * 4;
      edge_n = cyc + 1;
      if (st.rst) begin
         for (int l = 0; l < NL; l++) begin
            expq[l].delete();
            last_m[l] = '0;
         end
      end else if (st.en && !st.wr) begin
         for (int l = 0; l < NL; l++) begin
            e.due   = edge_n + l;
            e.valid = 1'b1;
            e.err   = !inr;
            e.data  = inr ? mem_m[off >> 2] : ERR;
            expq[l].push_back(e);
         end
      end else if (st.en) begin
         if (inr) begin
            for (int i = 0; i < 4; i++)
               if (st.s[i]) mem_m[off >> 2][8*i +: 8] = st.d[8*i +: 8];
         end else begin
            for (int l = 0; l < NL; l++) begin
               e.due   = edge_n + l;
               e.valid = 1'b0;
               e.err   = 1'b1;
               e.data  = '0;
               expq[l].push_back(e);
            end
         end
      end
      @(posedge clock);
      cyc = edge_n;
      #1;
   endtask

   // Expected outputs for latency index l at the current cycle.
   task automatic model_out(input int l, output bit ev, output bit ee,
                            output logic [31:0] ed);
      ev = 1'b0;
      ee = 1'b0;
      if (expq[l].size() > 0 && expq[l][0].due == cyc) begin
         ev = expq[l][0].valid;
         ee = expq[l][0].err;
         if (expq[l][0].valid) last_m[l] = expq[l][0].data;
         void'(expq[l].pop_front());
      end
      ed = last_m[l];
   endtask

   function automatic stim_t rq(input bit w, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s);
      stim_t st;
      st.rst = 1'b0;
      st.en  = 1'b1;
      st.wr  = w;
      st.a   = a;
      st.d   = d;
      st.s   = s;
      return st;
   endfunction

   function automatic stim_t idle();
      stim_t st;
      st = rq(1'b0, 32'h0, 32'h0, 4'h0);
      st.en = 1'b0;
      return st;
   endfunction

   task automatic test_reset();
      stim_t sq[$];
      bit ev, ee;
      logic [31:0] ed;
      stim_t r;
      r = rq(1'b0, BASE + 32'h10, 32'h0, 4'h0);
      r.rst = 1'b1;
      sq = '{r, r, idle(), idle()};
      foreach (sq[k]) begin
         drive(sq[k]);
         for (int l = 0; l < NL; l++) begin
            model_out(l, ev, ee, ed);
            n_checks++;
            if ({rvalid_o[l], err_o[l], rdata_o[l]} !== {ev, ee, ed}) begin
               n_fail++;
               $display("FAIL reset L%0d cyc%0d: got v%b e%b d%h want v%b e%b d%h",
                        l + 1, cyc, rvalid_o[l], err_o[l], rdata_o[l], ev, ee, ed);
            end
         end
      end
   endtask

   task automatic test_fill();
      bit ev, ee;
      logic [31:0] ed;
      for (int k = 0; k < DEPTH + 5; k++) begin
         if (k < DEPTH) drive(rq(1'b1, BASE + 32'(k * 4), $urandom, 4'hF));
         else drive(idle());
         for (int l = 0; l < NL; l++) begin
            model_out(l, ev, ee, ed);
            n_checks++;
            if ({rvalid_o[l], err_o[l], rdata_o[l]} !== {ev, ee, ed}) begin
               n_fail++;
               $display("FAIL fill L%0d cyc%0d: got v%b e%b d%h want v%b e%b d%h",
                        l + 1, cyc, rvalid_o[l], err_o[l], rdata_o[l], ev, ee, ed);
            end
         end
      end
   endtask

   task automatic test_write_read();
      stim_t sq[$];
      bit ev, ee;
      logic [31:0] ed;
      sq = '{rq(1'b1, BASE + 32'h10, 32'h1122_3344, 4'hF),
             rq(1'b0, BASE + 32'h10, 32'h0, 4'h0),
             idle(), idle(), idle(), idle(), idle()};
      foreach (sq[k]) begin
         drive(sq[k]);
         for (int l = 0; l < NL; l++) begin
            model_out(l, ev, ee, ed);
            n_checks++;
            if ({rvalid_o[l], err_o[l], rdata_o[l]} !== {ev, ee, ed}) begin
               n_fail++;
               $display("FAIL write_read L%0d cyc%0d: got v%b e%b d%h want v%b e%b d%h",
                        l + 1, cyc, rvalid_o[l], err_o[l], rdata_o[l], ev, ee, ed);
            end
         end
      end
   endtask

   task automatic test_strobe();
      stim_t sq[$];
      bit ev, ee;
      logic [31:0] ed;
      sq = '{rq(1'b1, BASE + 32'h10, 32'hAABB_CCDD, 4'b0101),
             rq(1'b0, BASE + 32'h12, 32'h0, 4'h0),
             rq(1'b1, BASE + 32'h20, 32'hFFFF_FFFF, 4'h0),
             rq(1'b0, BASE + 32'h20, 32'h0, 4'hF),
             idle(), idle(), idle(), idle(), idle()};
      foreach (sq[k]) begin
         drive(sq[k]);
         for (int l = 0; l < NL; l++) begin
            model_out(l, ev, ee, ed);
            n_checks++;
            if ({rvalid_o[l], err_o[l], rdata_o[l]} !== {ev, ee, ed}) begin
               n_fail++;
               $display("FAIL strobe L%0d cyc%0d: got v%b e%b d%h want v%b e%b d%h",
                        l + 1, cyc, rvalid_o[l], err_o[l], rdata_o[l], ev, ee, ed);
            end
         end
      end
   endtask

   task automatic test_read_then_write();
      stim_t sq[$];
      bit ev, ee;
      logic [31:0] ed;
      sq = '{rq(1'b0, BASE + 32'h10, 32'h0, 4'h0),
             rq(1'b1, BASE + 32'h10, 32'h0, 4'hF),
             rq(1'b0, BASE + 32'h10, 32'h0, 4'h0),
             idle(), idle(), idle(), idle(), idle()};
      foreach (sq[k]) begin
         drive(sq[k]);
         for (int l = 0; l < NL; l++) begin
            model_out(l, ev, ee, ed);
            n_checks++;
            if ({rvalid_o[l], err_o[l], rdata_o[l]} !== {ev, ee, ed}) begin
               n_fail++;
               $display("FAIL read_then_write L%0d cyc%0d: got v%b e%b d%h want v%b e%b d%h",
                        l + 1, cyc, rvalid_o[l], err_o[l], rdata_o[l], ev, ee, ed);
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      stim_t sq[$];
      bit ev, ee;
      logic [31:0] ed;
      sq = '{rq(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0),
             rq(1'b0, BASE + DEPTH * 4, 32'h0, 4'h0),
             rq(1'b1, BASE + DEPTH * 4, 32'h5555_5555, 4'hF),
             rq(1'b1, 32'h7FFF_FFFC, 32'h6666_6666, 4'hF),
             idle(),
             rq(1'b0, BASE, 32'h0, 4'h0),
             rq(1'b0, BASE + (DEPTH - 1) * 4, 32'h0, 4'h0),
             idle(), idle(), idle(), idle(), idle()};
      foreach (sq[k]) begin
         drive(sq[k]);
         for (int l = 0; l < NL; l++) begin
            model_out(l, ev, ee, ed);
            n_checks++;
            if ({rvalid_o[l], err_o[l], rdata_o[l]} !== {ev, ee, ed}) begin
               n_fail++;
               $display("FAIL out_of_range L%0d cyc%0d: got v%b e%b d%h want v%b e%b d%h",
                        l + 1, cyc, rvalid_o[l], err_o[l], rdata_o[l], ev, ee, ed);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t sq[$];
      stim_t r;
      bit ev, ee;
      logic [31:0] ed;
      for (int k = 0; k < 8; k++) sq.push_back(rq(1'b0, BASE + 32'(k * 8), 0, 0));
      for (int k = 0; k < 5; k++) sq.push_back(idle());
      for (int k = 0; k < 8; k++) begin
         r = rq(1'b0, BASE + 32'(k * 4 + 64), 0, 0);
         r.rst = (k == 5);
         sq.push_back(r);
      end
      for (int k = 0; k < 6; k++) sq.push_back(idle());
      foreach (sq[k]) begin
         drive(sq[k]);
         for (int l = 0; l < NL; l++) begin
            model_out(l, ev, ee, ed);
            n_checks++;
            if ({rvalid_o[l], err_o[l], rdata_o[l]} !== {ev, ee, ed}) begin
               n_fail++;
               $display("FAIL back_to_back L%0d cyc%0d: got v%b e%b d%h want v%b e%b d%h",
                        l + 1, cyc, rvalid_o[l], err_o[l], rdata_o[l], ev, ee, ed);
            end
         end
      end
   endtask

   task automatic test_random();
      stim_t r;
      bit ev, ee;
      logic [31:0] ed;
      for (int k = 0; k < 400; k++) begin
         if (k >= 390) begin
            r = idle();
         end else begin
            r = rq($urandom_range(0, 1), $urandom, $urandom, 4'($urandom));
            r.en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) != 0)
               r.a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            r.rst = ($urandom_range(0, 63) == 0);
            if (r.rst) r.wr = 1'b0;
         end
         drive(r);
         for (int l = 0; l < NL; l++) begin
            model_out(l, ev, ee, ed);
            n_checks++;
            if ({rvalid_o[l], err_o[l], rdata_o[l]} !== {ev, ee, ed}) begin
               n_fail++;
               $display("FAIL random L%0d cyc%0d: got v%b e%b d%h want v%b e%b d%h",
                        l + 1, cyc, rvalid_o[l], err_o[l], rdata_o[l], ev, ee, ed);
            end
         end
      end
   endtask

   initial begin
      for (int l = 0; l < NL; l++) last_m[l] = '0;
      reset = 1'b1;
      en    = 1'b0;
      wr    = 1'b0;
      addr  = '0;
      wdata = '0;
      wstrb = '0;
      test_reset();
      test_fill();
      test_write_read();
      test_strobe();
      test_read_then_write();
      test_out_of_range();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
